// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose:
//    Single-port word-organised data memory behind a valid/ready request and
//    response handshake. It services RV32I loads (LB, LH, LW, LBU, LHU) and
//    stores (SB, SH, SW). Every request goes through IDLE -> ACCESS -> RESPOND.
//    At most one request is in flight at a time.
//
// Configuration:
//    DATA_MEM_MISALIGN_TRAP_EN - When this macro is defined, misaligned
//                                half/word accesses are rejected with
//                                rsp_err. When it is undefined, the low
//                                address bits that cause the misalignment are
//                                ignored and the access is aligned down.
//
// Parameters:
//    DEPTH       - Number of 32-bit words in the storage array. Must be a
//                  power of two and at least 2.
//
// Ports:
//    clk         - Clock. All state changes on the rising edge.
//    reset       - Synchronous active-high reset. Takes priority over
//                  everything else.
//    req_valid   - A request is present.
//    req_ready   - The responder can accept a request. High only in IDLE.
//    req_write   - 1 = store, 0 = load.
//    req_addr    - Byte address. Bits above the word index are ignored.
//    req_wdata   - Store data, right-aligned.
//    req_funct3  - RV32I load/store width code.
//    rsp_valid   - A response is present. High only in RESPOND.
//    rsp_ready   - The requester accepts the response.
//    rsp_rdata   - Extended load result. It is 0 for stores and errors.
//    rsp_err     - The request was rejected and storage was not changed.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_MISALIGN = 1'b1;
`else
    localparam bit TRAP_MISALIGN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

    state_t             state_q;
    logic               reqWrite_q;
    logic [IDX_W+1:0]   reqAddr_q;
    logic [31:0]        reqWdata_q;
    logic [2:0]         reqFunct3_q;
    logic [31:0]        rspRdata_q;
    logic               rspErr_q;

    logic [31:0]        mem_q [DEPTH];

    logic [IDX_W-1:0]   wordIdx;
    logic [31:0]        rdWord;
    logic [7:0]         selByte;
    logic [15:0]        selHalf;
    logic               funct3Ok;
    logic               misaligned;
    logic               accessErr_d;
    logic [31:0]        loadData_d;
    logic [3:0]         storeMask;
    logic [31:0]        storeData;
    logic               memWe;

    // The address bits above the word index do not select a word.
    // They are folded together here only so that it is clear they are
    // deliberately left unused.
    logic               unusedAddrBits;
    assign unusedAddrBits = ^req_addr[31:IDX_W+2];

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESPOND);
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

    // This block decodes the captured request while the FSM is in ACCESS.
    // It produces the following:
    //    - the word index, which wraps modulo DEPTH;
    //    - the load result, already sign- or zero-extended;
    //    - the store byte-lane mask and the store data replicated to every lane;
    //    - the error flag.
    // For half and byte accesses, lane selection uses only the address bits that
    // are relevant to that width. As a result, when the trap is disabled, a
    // misaligned access naturally lands on the aligned-down lane.
    always_comb begin
        wordIdx    = reqAddr_q[IDX_W+1:2];
        rdWord     = mem_q[wordIdx];
        funct3Ok   = 1'b0;
        misaligned = 1'b0;
        loadData_d = 32'h0;
        storeMask  = 4'b0000;
        storeData  = 32'h0;

        case (reqAddr_q[1:0])
            2'd0:    selByte = rdWord[7:0];
            2'd1:    selByte = rdWord[15:8];
            2'd2:    selByte = rdWord[23:16];
            default: selByte = rdWord[31:24];
        endcase
        selHalf = reqAddr_q[1] ? rdWord[31:16] : rdWord[15:0];

        case (reqFunct3_q)
            3'b000: begin
                funct3Ok   = 1'b1;
                loadData_d = {{24{selByte[7]}}, selByte};
                storeMask  = 4'b0001 << reqAddr_q[1:0];
                storeData  = {4{reqWdata_q[7:0]}};
            end
            3'b001: begin
                funct3Ok   = 1'b1;
                misaligned = reqAddr_q[0];
                loadData_d = {{16{selHalf[15]}}, selHalf};
                storeMask  = reqAddr_q[1] ? 4'b1100 : 4'b0011;
                storeData  = {2{reqWdata_q[15:0]}};
            end
            3'b010: begin
                funct3Ok   = 1'b1;
                misaligned = |reqAddr_q[1:0];
                loadData_d = rdWord;
                storeMask  = 4'b1111;
                storeData  = reqWdata_q;
            end
            3'b100: begin
                funct3Ok   = !reqWrite_q;
                loadData_d = {24'h0, selByte};
            end
            3'b101: begin
                funct3Ok   = !reqWrite_q;
                misaligned = reqAddr_q[0];
                loadData_d = {16'h0, selHalf};
            end
            default: begin
                funct3Ok = 1'b0;
            end
        endcase

        accessErr_d = !funct3Ok || (TRAP_MISALIGN && misaligned);
        memWe       = (state_q == ACCESS) && reqWrite_q && !accessErr_d && !reset;
    end

    // This is the request/response FSM.
    // A request is captured only in IDLE, so a requester that holds req_valid
    // during ACCESS or RESPOND is simply not seen.
    // The response is registered at the closing edge of ACCESS and then held
    // until the requester takes it.
    // Reset wins over everything. Any pending response is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            reqWrite_q  <= 1'b0;
            reqAddr_q   <= '0;
            reqWdata_q  <= 32'h0;
            reqFunct3_q <= 3'b000;
            rspRdata_q  <= 32'h0;
            rspErr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        reqWrite_q  <= req_write;
                        reqAddr_q   <= req_addr[IDX_W+1:0];
                        reqWdata_q  <= req_wdata;
                        reqFunct3_q <= req_funct3;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    rspErr_q   <= accessErr_d;
                    rspRdata_q <= (reqWrite_q || accessErr_d) ? 32'h0 : loadData_d;
                    state_q    <= RESPOND;
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // This block performs the storage write with byte-lane masking.
    // The array has no reset, so its contents survive reset.
    // memWe already excludes the reset cycle, so a store that is in ACCESS on a
    // reset edge is not committed.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (storeMask[b]) begin
                    mem_q[wordIdx][8*b +: 8] <= storeData[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Purpose:
//    Self-checking bench for data_mem_responder.
//    A behavioural memory model computes the expected response whenever a
//    request is driven. That expected response is queued. It is popped and
//    compared once the DUT raises rsp_valid.
//    The bench builds with or without DATA_MEM_MISALIGN_TRAP_EN and adjusts
//    its model to match.
//
// Ports: none (top-level bench)
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        expQ [$];
    logic [31:0] modelMem [DEPTH];

    data_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // This is a watchdog in case some wait goes wrong in a way that the
    // bounded loops below do not catch.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checkCount, failCount);
        $fatal(1, "[TB] watchdog expired");
    end

    // This task performs a single comparison.
    // Every check in the bench goes through it, so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // This is the reference model of the memory.
    // It works byte by byte with shifts, and it updates modelMem for stores
    // that succeed.
    function automatic rsp_t modelAccess(input logic wr, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [2:0] f3);
        rsp_t        r;
        int          w;
        logic [1:0]  off;
        logic [31:0] word;
        logic [7:0]  bsel;
        logic [15:0] hsel;
        bit          bad;
        w       = int'(addr[9:2]);
        off     = addr[1:0];
        word    = modelMem[w];
        r.rdata = 32'h0;
        r.err   = 1'b0;
        if (wr) bad = !(f3 inside {3'b000, 3'b001, 3'b010});
        else    bad = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef DATA_MEM_MISALIGN_TRAP_EN
        if ((f3[1:0] == 2'b01 && off[0]) || (f3 == 3'b010 && off != 2'b00)) bad = 1'b1;
`endif
        if (bad) begin
            r.err = 1'b1;
            return r;
        end
        bsel = 8'(word >> (8 * int'(off)));
        hsel = off[1] ? word[31:16] : word[15:0];
        if (wr) begin
            case (f3)
                3'b000:  word[8*int'(off) +: 8] = wdata[7:0];
                3'b001:  if (off[1]) word[31:16] = wdata[15:0]; else word[15:0] = wdata[15:0];
                default: word = wdata;
            endcase
            modelMem[w] = word;
        end else begin
            case (f3)
                3'b000:  r.rdata = {{24{bsel[7]}}, bsel};
                3'b001:  r.rdata = {{16{hsel[15]}}, hsel};
                3'b010:  r.rdata = word;
                3'b100:  r.rdata = {24'h0, bsel};
                default: r.rdata = {16'h0, hsel};
            endcase
        end
        return r;
    endfunction

    // This task drives one request and follows it through to its response.
    // It:
    //    - waits, with a bound, for req_ready;
    //    - queues the model's expectation;
    //    - checks the latency, measured from the cycle the request is presented;
    //    - compares the response;
    //    - optionally stalls rsp_ready for holdCycles and checks stability.
    // With ghost set, the task keeps a competing store on the request port
    // during ACCESS/RESPOND. That store must never be captured.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input int holdCycles, input bit ghost,
                                 input string tag);
        int   waitCycles;
        rsp_t exp;
        @(negedge clk);
        waitCycles = 0;
        while (!req_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!req_ready) begin
            checkOutput({tag, " ready timeout"}, {31'h0, req_ready}, 32'd1);
            return;
        end
        expQ.push_back(modelAccess(wr, addr, wdata, f3));
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(negedge clk);
        if (ghost) begin
            req_write  = 1'b1;
            req_wdata  = 32'h0BADF00D;
            req_funct3 = 3'b010;
        end else begin
            req_valid = 1'b0;
        end
        checkOutput({tag, " ready low in ACCESS"}, {31'h0, req_ready}, 32'd0);
        waitCycles = 1;
        while (!rsp_valid && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput({tag, " latency"}, 32'(waitCycles), 32'd2);
        exp = expQ.pop_front();
        if (!rsp_valid) begin
            req_valid = 1'b0;
            return;
        end
        checkOutput({tag, " rdata"}, rsp_rdata, exp.rdata);
        checkOutput({tag, " err"}, {31'h0, rsp_err}, {31'h0, exp.err});
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput({tag, " stall valid"}, {31'h0, rsp_valid}, 32'd1);
            checkOutput({tag, " stall rdata"}, rsp_rdata, exp.rdata);
            checkOutput({tag, " stall ready"}, {31'h0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput({tag, " valid drops"}, {31'h0, rsp_valid}, 32'd0);
    endtask

    // This task launches a store and asserts reset while that store is in
    // ACCESS. The store must vanish: no write, no response, and the outputs
    // must be back at their reset values.
    task automatic applyResetInAccess(input logic [31:0] addr, input logic [31:0] wdata);
        int waitCycles;
        @(negedge clk);
        waitCycles = 0;
        while (!req_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst-in-access req_ready", {31'h0, req_ready}, 32'd1);
        checkOutput("rst-in-access rsp_valid", {31'h0, rsp_valid}, 32'd0);
        checkOutput("rst-in-access rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst-in-access rsp_err", {31'h0, rsp_err}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", {31'h0, req_ready}, 32'd1);
        checkOutput("reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset rsp_err", {31'h0, rsp_err}, 32'd0);
        reset = 1'b0;

        // Word store and load round trip.
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 1'b0, "SW 0x10");
        applyStimulus(1'b0, 32'h10, 32'h0,        3'b010, 0, 1'b0, "LW 0x10");

        // Byte store into a cleared word, then signed/unsigned byte loads.
        applyStimulus(1'b1, 32'h10, 32'h00000000, 3'b010, 0, 1'b0, "SW0 0x10");
        applyStimulus(1'b1, 32'h13, 32'h12345680, 3'b000, 0, 1'b0, "SB 0x13");
        applyStimulus(1'b0, 32'h13, 32'h0,        3'b000, 0, 1'b0, "LB 0x13");
        applyStimulus(1'b0, 32'h13, 32'h0,        3'b100, 0, 1'b0, "LBU 0x13");
        applyStimulus(1'b0, 32'h10, 32'h0,        3'b010, 0, 1'b0, "LW 0x10b");

        // Stalled response with a competing request held on the port.
        applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 5, 1'b1, "LW stall");
        applyStimulus(1'b0, 32'h10, 32'h0, 3'b010, 0, 1'b0, "LW after ghost");

        // Halfword lanes, preservation of untouched lanes, and address wrap.
        applyStimulus(1'b1, 32'h14, 32'h11223344, 3'b010, 0, 1'b0, "SW 0x14");
        applyStimulus(1'b1, 32'h16, 32'hFFFF8001, 3'b001, 0, 1'b0, "SH 0x16");
        applyStimulus(1'b0, 32'h16, 32'h0,        3'b001, 0, 1'b0, "LH 0x16");
        applyStimulus(1'b0, 32'h16, 32'h0,        3'b101, 0, 1'b0, "LHU 0x16");
        applyStimulus(1'b0, 32'h14, 32'h0,        3'b000, 0, 1'b0, "LB 0x14");
        applyStimulus(1'b0, 32'h14, 32'h0,        3'b001, 0, 1'b0, "LH 0x14");
        applyStimulus(1'b0, 32'h80000414, 32'h0,  3'b010, 0, 1'b0, "LW wrap");
        applyStimulus(1'b1, 32'h415, 32'h000000A5, 3'b000, 0, 1'b0, "SB wrap");
        applyStimulus(1'b0, 32'h14, 32'h0,        3'b010, 0, 1'b0, "LW after SB wrap");

        // Misaligned accesses. The model decides trap vs. align-down.
        applyStimulus(1'b0, 32'h12, 32'h0,        3'b010, 0, 1'b0, "LW 0x12");
        applyStimulus(1'b0, 32'h15, 32'h0,        3'b001, 0, 1'b0, "LH 0x15");
        applyStimulus(1'b1, 32'h17, 32'h00007777, 3'b001, 0, 1'b0, "SH 0x17");
        applyStimulus(1'b0, 32'h14, 32'h0,        3'b010, 0, 1'b0, "LW after SH 0x17");

        // A store interrupted by reset must not land.
        applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 0, 1'b0, "SW 0x20");
        applyResetInAccess(32'h20, 32'h12345678);
        applyStimulus(1'b0, 32'h20, 32'h0,        3'b010, 0, 1'b0, "LW 0x20");

        // Illegal width codes must be rejected without touching storage.
        applyStimulus(1'b0, 32'h20, 32'h0,        3'b011, 0, 1'b0, "load f3=011");
        applyStimulus(1'b0, 32'h20, 32'h0,        3'b110, 0, 1'b0, "load f3=110");
        applyStimulus(1'b1, 32'h20, 32'h55555555, 3'b111, 0, 1'b0, "store f3=111");
        applyStimulus(1'b1, 32'h20, 32'h55555555, 3'b100, 0, 1'b0, "store f3=100");
        applyStimulus(1'b0, 32'h20, 32'h0,        3'b010, 0, 1'b0, "LW 0x20 after err");

        checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words in the storage array (power of two).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port req_valid, input, 1, request present.
REQ-005 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-006 SHALL have port req_write, input, 1; 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-009 SHALL have port req_funct3, input, 3, RV32I load/store width code.
REQ-010 SHALL have port rsp_valid, output, 1, response present.
REQ-011 SHALL have port rsp_ready, input, 1, requester accepts response.
REQ-012 SHALL have port rsp_rdata, output, 32, load result, extended per funct3; 0 for stores and errors.
REQ-013 SHALL have port rsp_err, output, 1, request rejected; no storage change.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESPOND; req_ready=1 only in IDLE.
REQ-015 Handshake: request accepted when req_valid&&req_ready; all req_* fields captured on that edge; state -> ACCESS.
REQ-016 ACCESS lasts exactly one cycle: array read or byte-masked write at its closing edge; state -> RESPOND.
REQ-017 RESPOND: rsp_valid=1, rsp_rdata/rsp_err held stable until rsp_valid&&rsp_ready; then state -> IDLE, rsp_valid=0 next cycle.
REQ-018 Minimum request-to-response latency SHALL be 2 cycles (accept edge to rsp_valid high); throughput one request per 3 cycles with rsp_ready held high.
REQ-019 Word index = req_addr[log2(DEPTH)+1:2]; higher address bits ignored (wrap modulo DEPTH words).
REQ-020 Loads: funct3 000 LB sign-extend byte addr[1:0]; 001 LH sign-extend half addr[1]; 010 LW; 100 LBU, 101 LHU zero-extend.
REQ-021 Stores: funct3 000 SB writes byte lane addr[1:0] from wdata[7:0]; 001 SH writes half lane addr[1] from wdata[15:0]; 010 SW writes all lanes; untouched lanes preserved.
REQ-022 Any other funct3 (load or store) SHALL give rsp_err=1, rsp_rdata=0, no write.
REQ-023 A store followed by a load to the same word SHALL return the stored data (no stale read).
REQ-024 req_valid during ACCESS/RESPOND SHALL be ignored and not captured; requester holds it.

Reset
REQ-025 Reset SHALL force state IDLE, req_ready=1 on next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-026 Reset has priority over all events; a store in ACCESS on a reset edge SHALL NOT be committed; pending response discarded.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DATA_MEM_MISALIGN_TRAP_EN: when defined, LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL give rsp_err=1, rsp_rdata=0, no write.
REQ-029 When undefined, misaligned accesses SHALL ignore the offending low address bits (aligned down) and complete with rsp_err=0.

Verification
REQ-030 Reset, SW 0xDEADBEEF @0x10, LW @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after each accept.
REQ-031 SB 0x80 @0x13 onto word 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
REQ-032 rsp_ready held 0 for 5 cycles in RESPOND -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, new req_valid ignored.
REQ-033 LW @0x12: with macro -> rsp_err=1, rsp_rdata=0; without -> returns word @0x10, rsp_err=0.
REQ-034 Reset asserted in ACCESS of SW 0x12345678 @0x20 -> next LW @0x20 returns prior contents; funct3=011 request -> rsp_err=1.
